// File: rtl/proc_clk_ctrl_if.sv
// Run-control bundle between the system side and the processor clock controller.
// Latency: none (signal bundle only).
// Backpressure: none; all signals are level/pulse qualified every cycle.
//
// Ports (system side drives the controls, controller drives the status):
//   MODE[1:0]       run-mode select: 00 HALT, 01 RUN, 10 STEP, 11 HALT
//   RATE_SEL[2:0]   RUN tick rate, 0 = 10 MHz ... 7 = 1 Hz
//   STEP_BTN        raw asynchronous single-step pushbutton, active-high
//   HALT_REQ        processor halt request
//   CPU_EN          one-cycle clock-enable to the processor datapath
//   STATE[1:0]      controller state: 00 HALTED, 01 RUNNING, 10 STEPPING, 11 HALT_LOCK
//   CYCLE_CNT[15:0] number of CPU_EN pulses issued (wraps)
interface proc_clk_ctrl_if;
    logic [1:0]  MODE;
    logic [2:0]  RATE_SEL;
    logic        STEP_BTN;
    logic        HALT_REQ;
    logic        CPU_EN;
    logic [1:0]  STATE;
    logic [15:0] CYCLE_CNT;

    modport master (
        output MODE, RATE_SEL, STEP_BTN, HALT_REQ,
        input  CPU_EN, STATE, CYCLE_CNT
    );

    modport slave (
        input  MODE, RATE_SEL, STEP_BTN, HALT_REQ,
        output CPU_EN, STATE, CYCLE_CNT
    );
endinterface

// File: rtl/proc_clk_ctrl.sv
// Processor clock controller: decade prescaler, debounced single-step, run/step/halt FSM.
// Latency: CPU_EN one cycle after the selected tick (RUN) or after the step pulse (STEP).
// Backpressure: none; HALT_REQ suppresses the enable in the same cycle it is sampled.
//
// Ports:
//   CLK_50  sole clock, all flops update on its rising edge
//   RST     synchronous active-high reset
//   bus     proc_clk_ctrl_if.slave (MODE, RATE_SEL, STEP_BTN, HALT_REQ in;
//           CPU_EN, STATE, CYCLE_CNT out, all registered)
module proc_clk_ctrl #(
    parameter int FIRST_DIV       = 5,
    parameter int DECADE          = 10,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic           CLK_50,
    input  logic           RST,
    proc_clk_ctrl_if.slave bus
);
    localparam int W0 = (FIRST_DIV > 1) ? $clog2(FIRST_DIV) : 1;
    localparam int WD = (DECADE > 1) ? $clog2(DECADE) : 1;
    localparam int WB = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [W0-1:0] FIRST_TC  = W0'(FIRST_DIV - 1);
    localparam logic [WD-1:0] DECADE_TC = WD'(DECADE - 1);
    localparam logic [WB-1:0] DB_LAST   = WB'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] MODE_RUN  = 2'b01;
    localparam logic [1:0] MODE_STEP = 2'b10;

    typedef enum logic [1:0] {
        ST_HALTED    = 2'b00,
        ST_RUNNING   = 2'b01,
        ST_STEPPING  = 2'b10,
        ST_HALT_LOCK = 2'b11
    } state_t;

    // Prescaler: stage 0 divides by FIRST_DIV, stages 1..7 by DECADE.
    logic [W0-1:0]       pre0_q, pre0_d;
    logic [6:0][WD-1:0]  dec_q, dec_d;
    logic [7:0]          tc;
    logic [7:0]          tick;
    logic                tick_sel;

    // Step button path.
    logic                sync1_q, sync1_d;
    logic                sync2_q, sync2_d;
    logic                db_lvl_q, db_lvl_d;
    logic [WB-1:0]       db_cnt_q, db_cnt_d;
    logic                step_pulse_q, step_pulse_d;

    // Run-control FSM and outputs.
    state_t              state_q, state_d;
    logic                cpu_en_q, cpu_en_d;
    logic [15:0]         cyc_cnt_q, cyc_cnt_d;

    // tick[k] fires when every stage 0..k sits at terminal count, so its
    // period is FIRST_DIV * DECADE^k.
    always_comb begin
        logic acc;
        tc[0] = (pre0_q == FIRST_TC);
        for (int k = 1; k < 8; k++) begin
            tc[k] = (dec_q[k-1] == DECADE_TC);
        end
        acc = 1'b1;
        for (int k = 0; k < 8; k++) begin
            acc     = acc & tc[k];
            tick[k] = acc;
        end
    end

    // Free-running chain; a RATE_SEL change never disturbs it.
    always_comb begin
        pre0_d = tick[0] ? '0 : pre0_q + 1'b1;
        for (int k = 0; k < 7; k++) begin
            dec_d[k] = dec_q[k];
            if (tick[k]) begin
                dec_d[k] = tc[k+1] ? '0 : dec_q[k] + 1'b1;
            end
        end
    end

    assign tick_sel = tick[bus.RATE_SEL];

    // Two-flop synchronizer, then a run-length debounce: the level follows
    // the synchronized input only after DEBOUNCE_CYCLES consecutive
    // disagreeing cycles; any agreeing cycle restarts the count.
    always_comb begin
        sync1_d      = bus.STEP_BTN;
        sync2_d      = sync1_q;
        db_lvl_d     = db_lvl_q;
        db_cnt_d     = '0;
        step_pulse_d = 1'b0;
        if (sync2_q != db_lvl_q) begin
            if (db_cnt_q == DB_LAST) begin
                db_lvl_d     = sync2_q;
                step_pulse_d = sync2_q;   // rising edge of the debounced level only
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
    end

    // CPU_EN is registered: it is decided here and appears the next cycle,
    // which is why STEPPING is entered with cpu_en_d already set.
    always_comb begin
        state_d   = state_q;
        cpu_en_d  = 1'b0;
        cyc_cnt_d = cyc_cnt_q + {15'd0, cpu_en_q};
        case (state_q)
            ST_HALTED: begin
                if (bus.MODE == MODE_RUN) begin
                    state_d = ST_RUNNING;
                end else if ((bus.MODE == MODE_STEP) && step_pulse_q) begin
                    state_d  = ST_STEPPING;
                    cpu_en_d = 1'b1;
                end
            end
            ST_RUNNING: begin
                // A halt request swallows a coincident tick.
                if (bus.HALT_REQ) begin
                    state_d = ST_HALT_LOCK;
                end else begin
                    cpu_en_d = tick_sel;
                    if (bus.MODE != MODE_RUN) begin
                        state_d = ST_HALTED;
                    end
                end
            end
            ST_STEPPING: begin
                state_d = ST_HALTED;
            end
            ST_HALT_LOCK: begin
                // Only a HALT selection (00, or 11 which aliases it) releases the lock.
                if ((bus.MODE == 2'b00) || (bus.MODE == 2'b11)) begin
                    state_d = ST_HALTED;
                end
            end
            default: begin
                state_d = ST_HALTED;
            end
        endcase
    end

    always_ff @(posedge CLK_50) begin
        if (RST) begin
            pre0_q       <= '0;
            dec_q        <= '0;
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            db_lvl_q     <= 1'b0;
            db_cnt_q     <= '0;
            step_pulse_q <= 1'b0;
            state_q      <= ST_HALTED;
            cpu_en_q     <= 1'b0;
            cyc_cnt_q    <= '0;
        end else begin
            pre0_q       <= pre0_d;
            dec_q        <= dec_d;
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            db_lvl_q     <= db_lvl_d;
            db_cnt_q     <= db_cnt_d;
            step_pulse_q <= step_pulse_d;
            state_q      <= state_d;
            cpu_en_q     <= cpu_en_d;
            cyc_cnt_q    <= cyc_cnt_d;
        end
    end

    assign bus.CPU_EN    = cpu_en_q;
    assign bus.STATE     = state_q;
    assign bus.CYCLE_CNT = cyc_cnt_q;

endmodule

// File: tb/tb_proc_clk_ctrl.sv
// Bench for proc_clk_ctrl: directed scenarios plus random traffic against a reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_proc_clk_ctrl;
    localparam int FD  = 5;
    localparam int DEC = 10;
    localparam int DB  = 4;

    logic CLK_50 = 1'b0;
    logic RST;
    logic RST_W;

    proc_clk_ctrl_if bus();
    proc_clk_ctrl_if wbus();

    proc_clk_ctrl #(.FIRST_DIV(FD), .DECADE(DEC), .DEBOUNCE_CYCLES(DB)) dut (
        .CLK_50 (CLK_50),
        .RST    (RST),
        .bus    (bus)
    );

    // Second instance with FIRST_DIV=1 runs alongside to reach the counter wrap quickly.
    proc_clk_ctrl #(.FIRST_DIV(1), .DECADE(DEC), .DEBOUNCE_CYCLES(DB)) dut_w (
        .CLK_50 (CLK_50),
        .RST    (RST_W),
        .bus    (wbus)
    );

    always #5 CLK_50 = ~CLK_50;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic longint period(input int k);
        longint p = FD;
        for (int i = 0; i < k; i++) p = p * DEC;
        return p;
    endfunction

    // ---------------- reference model ----------------
    // Prescaler is a plain cycle count since reset: tick[k] fires when
    // count mod period(k) equals period(k)-1.
    longint      m_cyc;
    int          m_state;       // 0 HALTED, 1 RUNNING, 2 STEPPING, 3 HALT_LOCK
    bit          m_en;
    logic [15:0] m_cnt;
    bit          m_sp;
    bit          m_lvl;
    bit          rq[$];         // raw button samples in flight through the synchronizer
    bit          wq[$];         // synchronized samples since the last level change
    bit          m_tick, nx_en, nx_sp, m_s, all_diff;
    int          nx_state;
    logic [15:0] nx_cnt;

    always @(posedge CLK_50) begin
        if (RST) begin
            m_cyc = 0; m_state = 0; m_en = 0; m_cnt = 0; m_sp = 0; m_lvl = 0;
            rq = '{1'b0, 1'b0};
            wq.delete();
        end else begin
            m_tick   = (m_cyc % period(int'(bus.RATE_SEL))) == period(int'(bus.RATE_SEL)) - 1;
            nx_cnt   = m_cnt + 16'(m_en);
            nx_en    = 0;
            nx_state = m_state;
            case (m_state)
                0: if (bus.MODE == 2'd1) nx_state = 1;
                   else if (bus.MODE == 2'd2 && m_sp) begin nx_state = 2; nx_en = 1; end
                1: if (bus.HALT_REQ) nx_state = 3;
                   else begin
                       nx_en = m_tick;
                       if (bus.MODE != 2'd1) nx_state = 0;
                   end
                2: nx_state = 0;
                default: if (bus.MODE == 2'd0 || bus.MODE == 2'd3) nx_state = 0;
            endcase
            // Debounce as a sliding window: the level flips once the last DB
            // synchronized samples all disagree with it.
            m_s = rq[0];
            void'(rq.pop_front());
            rq.push_back(bus.STEP_BTN);
            wq.push_back(m_s);
            if (wq.size() > DB) void'(wq.pop_front());
            nx_sp = 0;
            if (wq.size() == DB) begin
                all_diff = 1;
                foreach (wq[i]) if (wq[i] == m_lvl) all_diff = 0;
                if (all_diff) begin
                    m_lvl = ~m_lvl;
                    nx_sp = m_lvl;
                    wq.delete();
                end
            end
            m_cyc++;
            m_state = nx_state;
            m_en    = nx_en;
            m_cnt   = nx_cnt;
            m_sp    = nx_sp;
        end
    end

    bit chk_on  = 0;
    bit prev_en = 0;
    always @(negedge CLK_50) begin
        if (chk_on) begin
            check_val("cpu_en", bus.CPU_EN, m_en);
            check_val("state", bus.STATE, m_state);
            check_val("cycle_cnt", bus.CYCLE_CNT, m_cnt);
            check_val("en_gap", prev_en & bus.CPU_EN, 0);
            prev_en = bus.CPU_EN;
        end
    end

    // ---------------- wrap instance ----------------
    int w_pulses  = 0;
    bit wrap_done = 0;
    initial begin
        RST_W = 1'b1;
        wbus.MODE = 2'b01; wbus.RATE_SEL = 3'd0; wbus.STEP_BTN = 1'b0; wbus.HALT_REQ = 1'b0;
        repeat (2) @(posedge CLK_50);
        #1 RST_W = 1'b0;
        for (int i = 0; i < 70000 && !wrap_done; i++) begin
            @(negedge CLK_50);
            if (w_pulses == 65535) check_val("wrap_ffff", wbus.CYCLE_CNT, 16'hFFFF);
            else if (w_pulses == 65536) begin
                check_val("wrap_0000", wbus.CYCLE_CNT, 16'h0000);
                wrap_done = 1;
            end else if (w_pulses % 4096 == 0) check_val("wrap_track", wbus.CYCLE_CNT, w_pulses[15:0]);
            if (wbus.CPU_EN) w_pulses++;
        end
    end

    // ---------------- directed + random stimulus ----------------
    task automatic step();
        @(posedge CLK_50);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        step();
        step();
        RST = 1'b0;
    endtask

    // Counts negedges up to and including the first one with CPU_EN high; -1 on timeout.
    task automatic wait_en(input int budget, output int waited);
        waited = -1;
        for (int i = 1; i <= budget; i++) begin
            @(negedge CLK_50);
            if (bus.CPU_EN) begin
                waited = i;
                break;
            end
        end
    endtask

    int pulses, w, last, cyc;

    initial begin
        RST = 1'b1;
        bus.MODE = 2'b00; bus.RATE_SEL = 3'd0; bus.STEP_BTN = 1'b0; bus.HALT_REQ = 1'b0;
        repeat (3) step();
        check_val("rst_state", bus.STATE, 0);
        check_val("rst_en", bus.CPU_EN, 0);
        check_val("rst_cnt", bus.CYCLE_CNT, 0);
        RST = 1'b0;
        chk_on = 1;

        // Scenario 1: RUN at the fastest rate, pulses every FD cycles.
        bus.MODE = 2'b01;
        pulses = 0; last = -1;
        for (int c = 0; c < 50; c++) begin
            @(negedge CLK_50);
            if (bus.CPU_EN) begin
                if (last >= 0) check_val("s1_gap", c - last, FD);
                last = c;
                pulses++;
            end
        end
        check_val("s1_cnt_range", (bus.CYCLE_CNT >= 16'd9 && bus.CYCLE_CNT <= 16'd11), 1);
        step();

        // Scenario 2: RATE_SEL=1 period, then a mid-period switch back to rate 0.
        bus.RATE_SEL = 3'd1;
        wait_en(120, w);
        check_val("s2_first_pulse", (w > 0), 1);
        wait_en(120, w);
        check_val("s2_period", w, FD * DEC);
        repeat (20) @(negedge CLK_50);
        step();
        bus.RATE_SEL = 3'd0;
        wait_en(12, w);
        check_val("s2_fast_within5", (w >= 1 && w <= 5), 1);

        // Scenario 3: a short press is rejected, a held press steps exactly once.
        bus.MODE = 2'b10;
        do_reset();
        bus.STEP_BTN = 1'b1;
        repeat (3) step();
        bus.STEP_BTN = 1'b0;
        pulses = 0;
        repeat (12) begin @(negedge CLK_50); if (bus.CPU_EN) pulses++; end
        check_val("s3_short_press", pulses, 0);
        step();
        bus.STEP_BTN = 1'b1;
        // 2 sync + DB debounce edges raise the level, the step pulse follows, then CPU_EN.
        wait_en(20, w);
        check_val("s3_step_latency", w, 8);
        pulses = 0;
        repeat (2) begin @(negedge CLK_50); if (bus.CPU_EN) pulses++; end
        step();
        bus.STEP_BTN = 1'b0;
        repeat (10) begin @(negedge CLK_50); if (bus.CPU_EN) pulses++; end
        check_val("s3_extra_pulses", pulses, 0);
        check_val("s3_cnt", bus.CYCLE_CNT, 1);
        check_val("s3_state", bus.STATE, 0);
        step();

        // Scenario 4: halt request on a tick cycle locks the controller.
        bus.MODE = 2'b01;
        do_reset();
        wait_en(20, w);
        step();
        repeat (3) step();          // next tick cycle
        bus.HALT_REQ = 1'b1;
        step();
        bus.HALT_REQ = 1'b0;
        check_val("s4_lock_state", bus.STATE, 3);
        check_val("s4_no_en", bus.CPU_EN, 0);
        pulses = 0;
        repeat (10) begin @(negedge CLK_50); if (bus.CPU_EN) pulses++; end
        check_val("s4_lock_pulses", pulses, 0);
        step();
        check_val("s4_lock_hold", bus.STATE, 3);
        bus.MODE = 2'b00;
        step();
        check_val("s4_to_halted", bus.STATE, 0);
        bus.MODE = 2'b01;
        step();
        check_val("s4_to_running", bus.STATE, 1);

        // Scenario 6a: reset during STEPPING, then a full re-debounce.
        bus.MODE = 2'b10;
        do_reset();
        bus.STEP_BTN = 1'b1;
        repeat (7) step();
        check_val("s6_stepping", bus.STATE, 2);
        check_val("s6_step_en", bus.CPU_EN, 1);
        RST = 1'b1;
        step();
        check_val("s6_rst_en", bus.CPU_EN, 0);
        check_val("s6_rst_state", bus.STATE, 0);
        check_val("s6_rst_cnt", bus.CYCLE_CNT, 0);
        RST = 1'b0;
        wait_en(20, w);
        check_val("s6_rehold_latency", w, 8);

        // Scenario 6b: reset mid-debounce must restart the count.
        step();
        bus.STEP_BTN = 1'b0;
        repeat (12) step();
        bus.STEP_BTN = 1'b1;
        repeat (4) step();
        RST = 1'b1;
        step();
        check_val("s6b_rst_state", bus.STATE, 0);
        check_val("s6b_rst_en", bus.CPU_EN, 0);
        RST = 1'b0;
        wait_en(20, w);
        check_val("s6b_rehold_latency", w, 8);
        step();
        bus.STEP_BTN = 1'b0;

        // Random traffic, every cycle checked against the model.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 15) == 0) bus.MODE = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 31) == 0) bus.RATE_SEL = 3'($urandom_range(0, 2));
            bus.HALT_REQ = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 5) == 0) bus.STEP_BTN = ~bus.STEP_BTN;
            RST = ($urandom_range(0, 299) == 0);
            step();
        end
        RST = 1'b0;

        cyc = 0;
        while (!wrap_done && cyc < 80000) begin
            @(posedge CLK_50);
            cyc++;
        end
        check_val("wrap_done", wrap_done, 1);

        chk_on = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/proc_clk_ctrl.md
PROC_CLK_CTRL -- requirements
Module: proc_clk_ctrl

Interface
REQ-001 Parameter FIRST_DIV, default 5, is the first prescaler stage divide ratio (50 MHz to 10 MHz).
REQ-002 Parameter DECADE, default 10, is the divide ratio of each following prescaler stage.
REQ-003 Parameter DEBOUNCE_CYCLES, default 500000, is the number of CLK_50 cycles STEP_BTN must hold a level before it is accepted.
REQ-004 CLK_50  input  1  sole clock; every flop in the block is updated on its rising edge.
REQ-005 RST  input  1  reset, synchronous and active-high.
REQ-006 MODE  input  2  run-mode select: 00 HALT, 01 RUN, 10 STEP, 11 treated as HALT.
REQ-007 RATE_SEL  input  3  RUN tick rate: 0=10 MHz, 1=1 MHz, ... 7=1 Hz (one decade per step).
REQ-008 STEP_BTN  input  1  raw, asynchronous single-step pushbutton, active-high.
REQ-009 HALT_REQ  input  1  processor halt request, sampled every cycle.
REQ-010 CPU_EN  output  1  registered one-cycle clock-enable to the processor datapath.
REQ-011 STATE  output  2  current FSM state: 00 HALTED, 01 RUNNING, 10 STEPPING, 11 HALT_LOCK.
REQ-012 CYCLE_CNT  output  16  count of CPU_EN pulses issued.

Function
REQ-013 The prescaler SHALL be a chain of one FIRST_DIV-stage counter followed by seven DECADE-stage counters, all free-running, with each stage advancing only on the terminal count of the stage before it.
REQ-014 tick[k] SHALL be a one-cycle pulse asserted when stages 0..k are all at terminal count, which gives a tick period of FIRST_DIV*DECADE^k cycles.
REQ-015 The selected tick SHALL be tick[RATE_SEL].
REQ-016 A RATE_SEL change SHALL NOT reset the prescaler; the new rate takes effect at the next tick of the newly selected stage.
REQ-017 STEP_BTN SHALL pass through a 2-flop synchronizer and then a debounce counter.
- The debounced level changes only after the synchronized input has differed from it for DEBOUNCE_CYCLES consecutive cycles.
- Any bounce restarts the count.
REQ-018 step_pulse SHALL be a one-cycle pulse on each 0->1 transition of the debounced level.
REQ-019 HALTED: CPU_EN=0. Transitions:
- MODE=01 -> RUNNING.
- MODE=10 with step_pulse -> STEPPING.
- Otherwise stay in HALTED.
REQ-020 RUNNING: CPU_EN is asserted the cycle after each selected tick. Transitions, highest priority first:
- HALT_REQ=1 -> HALT_LOCK.
- MODE!=01 -> HALTED.
REQ-021 STEPPING SHALL last exactly one cycle: CPU_EN=1 in that cycle, then the FSM goes to HALTED.
- The step pulse therefore appears one cycle after step_pulse, regardless of the tick.
REQ-022 HALT_LOCK: CPU_EN=0. The FSM stays here until MODE=00 is sampled, then goes to HALTED.
- A processor halt therefore cannot be resumed without passing through HALT.
REQ-023 When HALT_REQ and a tick occur in the same RUNNING cycle, the halt SHALL win and no CPU_EN is issued for that tick.
REQ-024 A step_pulse seen in any state other than HALTED with MODE=10 SHALL be discarded and not queued.
REQ-025 CPU_EN SHALL never be high on two consecutive cycles, except in RUNNING with FIRST_DIV=1 and RATE_SEL=0.
REQ-026 CYCLE_CNT SHALL increment by 1 in the cycle after each CPU_EN pulse and wrap from 0xFFFF to 0x0000.
REQ-027 STATE SHALL reflect the registered FSM state, with no combinational path from the inputs.

Reset
REQ-028 While RST=1 on a clock edge, the following SHALL be cleared:
- FSM to HALTED, CPU_EN=0, CYCLE_CNT=0.
- All prescaler counters to 0.
- Synchronizer flops, debounced level and debounce counter to 0.
REQ-029 RST asserted in any state, including mid-debounce or in STEPPING, SHALL abort the operation in progress; no CPU_EN is issued in the cycle after reset.
REQ-030 After RST deasserts, the FSM SHALL re-evaluate MODE from HALTED on the next edge.

Verification (FIRST_DIV=5, DECADE=10, DEBOUNCE_CYCLES=4)
REQ-031 Scenario 1: RST, then MODE=01, RATE_SEL=0 for 50 cycles -> CPU_EN pulses every 5 cycles, CYCLE_CNT reaches 10 (+/-1 for phase).
REQ-032 Scenario 2: RUN with RATE_SEL=1 -> CPU_EN period is 50 cycles; switch to RATE_SEL=0 mid-period -> the next CPU_EN comes within 5 cycles.
REQ-033 Scenario 3: MODE=10, STEP_BTN high for 3 cycles then low -> no CPU_EN. STEP_BTN then held high for 10 cycles -> exactly one CPU_EN, and it follows the debounced edge by one cycle; CYCLE_CNT=1.
REQ-034 Scenario 4: RUNNING with HALT_REQ pulsed on a tick cycle -> STATE=11, no CPU_EN for that tick. MODE=01 held -> stays in 11. MODE=00 -> STATE=00. MODE=01 -> STATE=01.
REQ-035 Scenario 5: force CYCLE_CNT near wrap by running 65536 pulses at RATE_SEL=0 -> the count goes 0xFFFF then 0x0000.
REQ-036 Scenario 6: RST asserted during STEPPING and during a debounce count -> CPU_EN=0 and STATE=00 next cycle, CYCLE_CNT=0, and the button must be re-held for the full DEBOUNCE_CYCLES.
